// File: rtl/range_parser.sv
// range_parser -- streams ASCII "lo-hi" pairs separated by ',' or LF and
// hands each parsed pair to a downstream stage with a valid/ready handshake.
//
// Ports
//   clock        rising-edge clock for all state
//   reset        synchronous, active-high
//   byte_in      ASCII character
//   byte_valid   byte_in holds a character
//   byte_last    byte_in is the final character of the stream
//   byte_ready   parser accepts a character this cycle (LO/HI only)
//   range_lo     parsed start bound
//   range_hi     parsed end bound
//   range_valid  range_lo/range_hi hold a complete pair
//   range_ready  downstream consumes the pair
//   range_cnt    number of pairs handed off (wraps)
//   done         stream fully parsed, sticky until reset
//   err          malformed input or overflow, sticky until reset
module range_parser #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] range_lo,
  output logic [DATA_WIDTH-1:0] range_hi,
  output logic                  range_valid,
  input  logic                  range_ready,
  output logic [CNT_WIDTH-1:0]  range_cnt,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_LO   = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int WW = DATA_WIDTH + 4;
  localparam logic [WW-1:0] TEN = WW'(10);

  logic [2:0]            state, state_nx;
  logic [DATA_WIDTH-1:0] acc_lo, acc_hi;
  logic                  seen_lo, seen_hi;
  logic                  last_pend, last_nx;

  // character classes
  logic is_digit, is_dash, is_sep, is_skip;
  logic [3:0] dval;

  assign is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
  assign is_dash  = (byte_in == 8'h2D);
  assign is_sep   = (byte_in == 8'h2C) || (byte_in == 8'h0A);
  assign is_skip  = (byte_in == 8'h0D) || (byte_in == 8'h20);
  assign dval     = byte_in[3:0];  // '0'..'9' are 0x30..0x39

  // Accumulate at full precision: 4 guard bits hold acc*10+9 for any acc,
  // so any nonzero guard bit is an overflow of the bound width.
  logic [DATA_WIDTH-1:0] acc_cur, acc_next;
  logic [WW-1:0]         acc_wide;
  logic                  ovf;

  assign acc_cur  = (state == S_HI) ? acc_hi : acc_lo;
  assign acc_wide = ({4'b0000, acc_cur} * TEN) + WW'(dval);
  assign ovf      = |acc_wide[WW-1:DATA_WIDTH];
  assign acc_next = acc_wide[DATA_WIDTH-1:0];

  // Upper bound as it will be loaded: a final digit in HI is absorbed
  // into the bound on the same edge that terminates the pair.
  logic [DATA_WIDTH-1:0] emit_hi;
  logic                  lo_gt_hi;

  assign emit_hi  = is_digit ? acc_next : acc_hi;
  assign lo_gt_hi = acc_lo > emit_hi;

  // Handshake outputs are pure decodes of the state register, so neither
  // byte_valid nor range_ready reaches any output combinationally.
  assign byte_ready  = (state == S_LO) || (state == S_HI);
  assign range_valid = (state == S_EMIT);
  assign done        = (state == S_DONE);
  assign err         = (state == S_ERR);

  logic take, handoff, acc_wr, emit;

  assign take    = byte_valid && byte_ready;
  assign handoff = (state == S_EMIT) && range_ready;

  always_comb begin
    state_nx = state;
    acc_wr   = 1'b0;
    emit     = 1'b0;
    last_nx  = last_pend;
    case (state)
      S_LO: begin
        if (take) begin
          if (is_digit) begin
            // a stream cannot end halfway through a pair
            if (ovf || byte_last) state_nx = S_ERR;
            else                  acc_wr   = 1'b1;
          end else if (is_dash) begin
            state_nx = (seen_lo && !byte_last) ? S_HI : S_ERR;
          end else if (is_sep || is_skip) begin
            // blank separators are allowed between pairs; once a lower
            // bound has started, only '-' or blanks may follow
            if (byte_last)              state_nx = seen_lo ? S_ERR : S_DONE;
            else if (is_sep && seen_lo) state_nx = S_ERR;
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_HI: begin
        if (take) begin
          if (is_digit) begin
            if (ovf) begin
              state_nx = S_ERR;
            end else if (byte_last) begin
              if (lo_gt_hi) begin
                state_nx = S_ERR;
              end else begin
                state_nx = S_EMIT;
                emit     = 1'b1;
                last_nx  = 1'b1;
              end
            end else begin
              acc_wr = 1'b1;
            end
          end else if (is_sep) begin
            if (!seen_hi || lo_gt_hi) begin
              state_nx = S_ERR;
            end else begin
              state_nx = S_EMIT;
              emit     = 1'b1;
              last_nx  = byte_last;
            end
          end else if (is_skip) begin
            if (byte_last) state_nx = S_ERR;
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_EMIT: begin
        if (range_ready) begin
          state_nx = last_pend ? S_DONE : S_LO;
          last_nx  = 1'b0;
        end
      end
      default: ;  // DONE and ERR hold until reset
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_LO;
      acc_lo    <= '0;
      acc_hi    <= '0;
      seen_lo   <= 1'b0;
      seen_hi   <= 1'b0;
      last_pend <= 1'b0;
      range_lo  <= '0;
      range_hi  <= '0;
      range_cnt <= '0;
    end else begin
      state     <= state_nx;
      last_pend <= last_nx;
      if (acc_wr) begin
        if (state == S_HI) begin
          acc_hi  <= acc_next;
          seen_hi <= 1'b1;
        end else begin
          acc_lo  <= acc_next;
          seen_lo <= 1'b1;
        end
      end
      // output registers are only written on entry to EMIT, so the pair
      // stays put for as long as downstream stalls
      if (emit) begin
        range_lo <= acc_lo;
        range_hi <= emit_hi;
      end
      if (handoff) begin
        range_cnt <= range_cnt + CNT_WIDTH'(1);
        acc_lo    <= '0;
        acc_hi    <= '0;
        seen_lo   <= 1'b0;
        seen_hi   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/range_parser.md
RANGE_PARSER -- requirements
Module: range_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the width of each parsed bound.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the emitted-range counter.
REQ-003 SHALL have ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- byte_in  in  8  ASCII input character.
- byte_valid  in  1  byte_in holds a character.
- byte_last  in  1  qualifies byte_in as the final character of the input stream.
- byte_ready  out  1  parser accepts byte_in this cycle.
- range_lo  out  DATA_WIDTH  parsed start bound.
- range_hi  out  DATA_WIDTH  parsed end bound.
- range_valid  out  1  range_lo/range_hi hold a complete pair.
- range_ready  in  1  downstream counter stage consumes the pair.
- range_cnt  out  CNT_WIDTH  number of pairs handed off.
- done  out  1  stream fully parsed; sticky.
- err  out  1  malformed input or overflow; sticky.

Function
REQ-004 SHALL complete a byte handshake on any rising edge where byte_valid and byte_ready are both 1; a byte with byte_valid=0 SHALL be ignored.
REQ-005 SHALL implement the FSM states LO, HI, EMIT, DONE and ERR; reset enters LO.
REQ-006 LO/HI, digit '0'-'9': acc <= acc*10 + (c-'0') into the current bound; set the per-bound digit-seen flag.
REQ-007 LO, '-' with ≥1 digit: go to HI.
- '-' with zero digits -> ERR.
REQ-008 HI, ',' or LF (0x0A) with ≥1 digit: go to EMIT, loading range_lo/range_hi.
- ',' or LF with zero digits -> ERR.
REQ-009 LO with zero digits, ',' or LF: ignored (allows a trailing separator or blank line).
REQ-010 CR (0x0D) and space (0x20): ignored in LO and HI.
REQ-011 Any other character in LO or HI -> ERR.
REQ-012 Overflow -> ERR, detected at full precision. Overflow means acc*10 + digit exceeds 2^DATA_WIDTH-1.
REQ-013 EMIT: range_valid=1 and byte_ready=0.
- range_lo/range_hi SHALL be stable until the cycle after range_ready=1 is sampled.
- On handoff: range_cnt increments (wraps modulo 2^CNT_WIDTH), both accumulators and digit flags clear, state returns to LO.
- If the terminating byte carried byte_last=1, state goes to DONE instead of LO.
REQ-014 Latency: range_valid SHALL assert on the first rising edge after the terminating byte is accepted (1 cycle). With range_ready held 1, a pair occupies EMIT for exactly 1 cycle.
REQ-015 byte_last=1 handling in LO/HI:
- Digit in HI: the digit is absorbed, the pair goes to EMIT, then DONE.
- Terminator in HI: as REQ-008, then DONE.
- In LO with zero digits on a separator/ignorable character: go to DONE directly.
- Any other byte_last case -> ERR.
REQ-016 range_lo > range_hi at termination -> ERR; no pair is emitted.
REQ-017 DONE and ERR SHALL be absorbing until reset, with byte_ready=0 and range_valid=0.
- done=1 only in DONE; err=1 only in ERR.
REQ-018 byte_ready SHALL be 1 exactly in states LO and HI, and SHALL be independent of byte_valid (no combinational path from byte_valid).
REQ-019 range_valid SHALL be registered; there SHALL be no combinational path from range_ready to any output.

Reset
REQ-020 While reset=1 at a rising edge, on the following cycle:
- state=LO;
- accumulators and flags cleared;
- range_lo=range_hi=0, range_valid=0, range_cnt=0, done=0, err=0;
- byte_ready=1 after reset deasserts.
REQ-021 Reset asserted mid-number or during EMIT SHALL discard the partial or pending pair; no handoff completes on that edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- "11-22,95-115\n" (last on LF), range_ready=1 -> pairs (11,22), (95,115) each 1 cycle after its terminator; range_cnt=2; done=1; err=0.
- "998-1012" (last on '2'), range_ready held 0 for 5 cycles after range_valid -> range_valid held, (998,1012) stable, byte_ready=0 throughout; handoff on first range_ready=1, then done=1.
- DATA_WIDTH=64, "18446744073709551615-18446744073709551616" -> first bound accepted; ERR on the final '6'; err=1, range_cnt=0.
- "5-3," -> err=1, no range_valid pulse; "1-x" -> err=1 when 'x' is accepted.
- "12-34\r\n\n" (last on final LF) -> CR ignored, blank line ignored, one pair (12,34), done=1.
- reset after "45-6" with no terminator, then "1-2," with last -> only (1,2) emitted; range_cnt=1.
